maquina_de_lavar_prog: RTL and testbench

Programmable washing-machine sequencer. Successor of the fixed single-rinse controller: phase durations are timed internally, the rinse count is a parameter, fill and drain are supervised by timeouts, and the wash can be cancelled. It sits between the front-panel logic (`inicio`, `cancelar`, `pausa`) and the actuator drivers (pump, drain valve, motor modes). It reads the level sensors `cheio` and `vazio`.

---
 rtl/maquina_de_lavar_prog_pkg.sv | 21 ++
 rtl/maquina_de_lavar_prog_if.sv | 31 +++
 rtl/maquina_de_lavar_prog_temporizador.sv | 31 +++
 rtl/maquina_de_lavar_prog.sv | 199 +++++++++++++++++++
 tb/tb_maquina_de_lavar_prog.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/maquina_de_lavar_prog_pkg.sv
// Shared types for the programmable washing-machine sequencer: state codes,
// default timer width and the "machine busy" helper.
package maquina_pkg;

  localparam int TW_DEF = 16;

  typedef enum logic [2:0] {
    ESPERA      = 3'd0,
    ENCHER      = 3'd1,
    AGITAR      = 3'd2,
    GIRAR       = 3'd3,
    ESVAZIAR    = 3'd4,
    CENTRIFUGAR = 3'd5,
    ERRO        = 3'd6
  } estado_t;

  function automatic logic fase_ocupada(input estado_t e);
    return (e != ESPERA) && (e != ERRO);
  endfunction

endpackage

// File: rtl/maquina_de_lavar_prog_if.sv
// Front-panel, level-sensor and actuator signals of the washer sequencer.
// master = panel/sensor side, slave = sequencer.
interface maquina_if;
  logic       inicio;
  logic       cancelar;
  logic       pausa;
  logic       cheio;
  logic       vazio;
  logic       bomba_agua;
  logic       valvula_saida;
  logic       modo_agitar;
  logic       modo_girar;
  logic       modo_centrifugar;
  logic       ocupado;
  logic       fim;
  logic       erro;
  logic [2:0] estado;
  logic [2:0] passe;

  modport master (
    output inicio, cancelar, pausa, cheio, vazio,
    input  bomba_agua, valvula_saida, modo_agitar, modo_girar, modo_centrifugar,
    input  ocupado, fim, erro, estado, passe
  );

  modport slave (
    input  inicio, cancelar, pausa, cheio, vazio,
    output bomba_agua, valvula_saida, modo_agitar, modo_girar, modo_centrifugar,
    output ocupado, fim, erro, estado, passe
  );
endinterface

// File: rtl/maquina_de_lavar_prog_temporizador.sv
// Phase timer: clear/enable counter that flags when it sits on the
// programmed terminal value (phase length minus one).
module temporizador #(
  parameter int TW = maquina_pkg::TW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_limpar,
  input  logic          i_habilitar,
  input  logic [TW-1:0] i_limite,
  output logic          o_expira
);

  logic [TW-1:0] r_contagem;

  // Counter register: clear has priority over counting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_contagem <= {TW{1'b0}};
    end else if (i_limpar) begin
      r_contagem <= {TW{1'b0}};
    end else if (i_habilitar) begin
      r_contagem <= r_contagem + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      r_contagem <= r_contagem;
    end
  end

  assign o_expira = (r_contagem == i_limite);

endmodule

// File: rtl/maquina_de_lavar_prog.sv
// Programmable washing-machine sequencer (fill/agitate/turn/drain/spin).
// Optional pause feature enabled by defining MAQUINA_PAUSA_EN.
module maquina_de_lavar_prog
  import maquina_pkg::*;
#(
  parameter int TW            = TW_DEF,
  parameter int T_AGITAR      = 100,
  parameter int T_GIRAR       = 50,
  parameter int T_CENTRIFUGAR = 200,
  parameter int T_TIMEOUT     = 1000,
  parameter int N_ENXAGUE     = 2
) (
  input logic      clock,
  input logic      reset_n,
  maquina_if.slave bus
);

  localparam logic [TW-1:0] L_AGITAR      = TW'(T_AGITAR - 1);
  localparam logic [TW-1:0] L_GIRAR       = TW'(T_GIRAR - 1);
  localparam logic [TW-1:0] L_CENTRIFUGAR = TW'(T_CENTRIFUGAR - 1);
  localparam logic [TW-1:0] L_TIMEOUT     = TW'(T_TIMEOUT - 1);
  localparam logic [2:0]    L_ENXAGUE     = 3'(N_ENXAGUE);

  estado_t       r_estado;
  estado_t       w_prox;
  logic [2:0]    r_passe;
  logic [2:0]    w_passe_prox;
  logic          r_abort;
  logic          w_abort_prox;
  logic          r_fim;
  logic          w_fim_prox;
  logic          w_expira;
  logic          w_pausado;
  logic          w_cancela;
  logic [TW-1:0] w_limite;

`ifdef MAQUINA_PAUSA_EN
  assign w_pausado = bus.pausa &&
                     ((r_estado == AGITAR) || (r_estado == GIRAR) || (r_estado == CENTRIFUGAR));
`else
  // Pause disabled: the port is present but has no effect.
  assign w_pausado = bus.pausa & 1'b0;
`endif

  assign w_cancela = bus.cancelar &&
                     ((r_estado == ENCHER) || (r_estado == AGITAR) || (r_estado == GIRAR));

  // Terminal count for the current phase; fill/drain use the timeout.
  always_comb begin
    w_limite = L_TIMEOUT;
    case (r_estado)
      AGITAR:      w_limite = L_AGITAR;
      GIRAR:       w_limite = L_GIRAR;
      CENTRIFUGAR: w_limite = L_CENTRIFUGAR;
      default:     w_limite = L_TIMEOUT;
    endcase
  end

  temporizador #(.TW(TW)) u_temporizador (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_limpar    (w_prox != r_estado),
    .i_habilitar (fase_ocupada(r_estado) && !w_pausado),
    .i_limite    (w_limite),
    .o_expira    (w_expira)
  );

  // Next-state logic: cancel beats sensor, sensor beats timer/timeout.
  always_comb begin
    w_prox       = r_estado;
    w_passe_prox = r_passe;
    w_abort_prox = r_abort;
    w_fim_prox   = 1'b0;
    case (r_estado)
      ESPERA: begin
        if (bus.inicio) begin
          w_prox       = ENCHER;
          w_passe_prox = 3'd0;
          w_abort_prox = 1'b0;
        end else begin
          w_prox = ESPERA;
        end
      end
      ENCHER: begin
        if (w_cancela) begin
          w_prox       = ESVAZIAR;
          w_abort_prox = 1'b1;
        end else if (bus.cheio) begin
          w_prox = AGITAR;
        end else if (w_expira) begin
          w_prox = ERRO;
        end else begin
          w_prox = ENCHER;
        end
      end
      AGITAR: begin
        if (w_cancela) begin
          w_prox       = ESVAZIAR;
          w_abort_prox = 1'b1;
        end else if (w_pausado) begin
          w_prox = AGITAR;
        end else if (w_expira) begin
          w_prox = (r_passe == 3'd0) ? GIRAR : ESVAZIAR;
        end else begin
          w_prox = AGITAR;
        end
      end
      GIRAR: begin
        if (w_cancela) begin
          w_prox       = ESVAZIAR;
          w_abort_prox = 1'b1;
        end else if (w_pausado) begin
          w_prox = GIRAR;
        end else if (w_expira) begin
          w_prox = ESVAZIAR;
        end else begin
          w_prox = GIRAR;
        end
      end
      ESVAZIAR: begin
        if (bus.vazio) begin
          if (r_abort) begin
            w_prox       = ESPERA;
            w_abort_prox = 1'b0;
          end else if (r_passe < L_ENXAGUE) begin
            w_prox       = ENCHER;
            w_passe_prox = r_passe + 3'd1;
          end else begin
            w_prox = CENTRIFUGAR;
          end
        end else if (w_expira) begin
          w_prox = ERRO;
        end else begin
          w_prox = ESVAZIAR;
        end
      end
      CENTRIFUGAR: begin
        if (w_pausado) begin
          w_prox = CENTRIFUGAR;
        end else if (w_expira) begin
          w_prox     = ESPERA;
          w_fim_prox = 1'b1;
        end else begin
          w_prox = CENTRIFUGAR;
        end
      end
      ERRO: begin
        w_prox = ERRO;
      end
      default: begin
        w_prox       = ESPERA;
        w_passe_prox = 3'd0;
        w_abort_prox = 1'b0;
      end
    endcase
  end

  // State, pass counter, abort flag and completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= ESPERA;
      r_passe  <= 3'd0;
      r_abort  <= 1'b0;
      r_fim    <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_passe  <= w_passe_prox;
      r_abort  <= w_abort_prox;
      r_fim    <= w_fim_prox;
    end
  end

  // Moore decode of the state register; a pause idles the motor only.
  always_comb begin
    bus.bomba_agua       = 1'b0;
    bus.valvula_saida    = 1'b0;
    bus.modo_agitar      = 1'b0;
    bus.modo_girar       = 1'b0;
    bus.modo_centrifugar = 1'b0;
    case (r_estado)
      ENCHER:      bus.bomba_agua = 1'b1;
      AGITAR:      bus.modo_agitar = !w_pausado;
      GIRAR:       bus.modo_girar = !w_pausado;
      ESVAZIAR:    bus.valvula_saida = 1'b1;
      CENTRIFUGAR: begin
        bus.valvula_saida    = 1'b1;
        bus.modo_centrifugar = !w_pausado;
      end
      default:     bus.bomba_agua = 1'b0;
    endcase
  end

  assign bus.ocupado = fase_ocupada(r_estado);
  assign bus.erro    = (r_estado == ERRO);
  assign bus.fim     = r_fim;
  assign bus.estado  = r_estado;
  assign bus.passe   = r_passe;

endmodule

// File: tb/tb_maquina_de_lavar_prog.sv
// Directed self-checking bench for maquina_de_lavar_prog (short phase times).
module tb_maquina_de_lavar_prog;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   n_centr;
  int   n;
  int   na;
  int   base_centr;

  maquina_if bus ();

  maquina_de_lavar_prog #(
    .TW            (16),
    .T_AGITAR      (4),
    .T_GIRAR       (3),
    .T_CENTRIFUGAR (5),
    .T_TIMEOUT     (10),
    .N_ENXAGUE     (1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial n_centr = 0;
  always @(posedge clock) if (bus.modo_centrifugar === 1'b1) n_centr <= n_centr + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] saidas();
    return {bus.bomba_agua, bus.valvula_saida, bus.modo_agitar, bus.modo_girar,
            bus.modo_centrifugar, bus.ocupado, bus.fim, bus.erro};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic iniciar();
    bus.inicio = 1'b1;
    step();
    bus.inicio = 1'b0;
  endtask

  // Called on the first sample of a fill/drain state: raise the sensor two cycles in.
  task automatic sensor_apos2(input bit vaz);
    step();
    step();
    if (vaz) bus.vazio = 1'b1;
    else     bus.cheio = 1'b1;
    step();
    bus.vazio = 1'b0;
    bus.cheio = 1'b0;
  endtask

  task automatic conta_fase(input logic [2:0] st, output int dur, output int n_ag);
    int guard;
    dur = 0;
    n_ag = 0;
    guard = 0;
    while (bus.estado === st && guard < 60) begin
      if (bus.modo_agitar === 1'b1) n_ag++;
      dur++;
      guard++;
      step();
    end
  endtask

  task automatic ate_centrifugar();
    int d;
    int a;
    iniciar();
    sensor_apos2(1'b0);
    conta_fase(3'd2, d, a);
    conta_fase(3'd3, d, a);
    sensor_apos2(1'b1);
    sensor_apos2(1'b0);
    conta_fase(3'd2, d, a);
    sensor_apos2(1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus.inicio = 1'b0;
    bus.cancelar = 1'b0;
    bus.pausa = 1'b0;
    bus.cheio = 1'b0;
    bus.vazio = 1'b0;
    step();
    step();
    check("reset_estado", 16'(bus.estado), 16'd0);
    check("reset_saidas", 16'(saidas()), 16'h00);
    check("reset_passe", 16'(bus.passe), 16'd0);
    reset_n = 1'b1;
    step();
    check("idle_estado", 16'(bus.estado), 16'd0);

    // Normal run
    base_centr = n_centr;
    iniciar();
    check("run_encher", 16'(bus.estado), 16'd1);
    check("run_bomba", 16'(saidas()), 16'h84);
    check("run_passe0", 16'(bus.passe), 16'd0);
    sensor_apos2(1'b0);
    check("run_agitar0", 16'(bus.estado), 16'd2);
    conta_fase(3'd2, n, na);
    check("run_agitar0_dur", 16'(n), 16'd4);
    check("run_agitar0_mot", 16'(na), 16'd4);
    check("run_girar", 16'(bus.estado), 16'd3);
    check("run_girar_out", 16'(saidas()), 16'h14);
    conta_fase(3'd3, n, na);
    check("run_girar_dur", 16'(n), 16'd3);
    check("run_esvaziar0", 16'(bus.estado), 16'd4);
    check("run_valvula", 16'(saidas()), 16'h44);
    sensor_apos2(1'b1);
    check("run_encher1", 16'(bus.estado), 16'd1);
    check("run_passe1", 16'(bus.passe), 16'd1);
    sensor_apos2(1'b0);
    check("run_agitar1", 16'(bus.estado), 16'd2);
    conta_fase(3'd2, n, na);
    check("run_agitar1_mot", 16'(na), 16'd4);
    check("run_esvaziar1", 16'(bus.estado), 16'd4);
    sensor_apos2(1'b1);
    check("run_centrif", 16'(bus.estado), 16'd5);
    check("run_centrif_out", 16'(saidas()), 16'h4C);
    conta_fase(3'd5, n, na);
    check("run_centrif_dur", 16'(n), 16'd5);
    check("run_fim_estado", 16'(bus.estado), 16'd0);
    check("run_fim_out", 16'(saidas()), 16'h02);
    step();
    check("run_fim_pulse", 16'(bus.fim), 16'd0);
    check("run_centr_count", 16'(n_centr - base_centr), 16'd5);

    // Fill timeout to ERRO
    iniciar();
    conta_fase(3'd1, n, na);
    check("to_encher_dur", 16'(n), 16'd10);
    check("to_erro", 16'(bus.estado), 16'd6);
    check("to_erro_out", 16'(saidas()), 16'h01);
    bus.inicio = 1'b1;
    step();
    step();
    check("to_erro_sticky", 16'(bus.estado), 16'd6);
    bus.inicio = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("to_reset_estado", 16'(bus.estado), 16'd0);
    check("to_reset_out", 16'(saidas()), 16'h00);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("to_idle", 16'(bus.estado), 16'd0);

    // Cancel during GIRAR
    base_centr = n_centr;
    iniciar();
    sensor_apos2(1'b0);
    conta_fase(3'd2, n, na);
    check("cx_girar", 16'(bus.estado), 16'd3);
    step();
    step();
    bus.cancelar = 1'b1;
    step();
    bus.cancelar = 1'b0;
    check("cx_esvaziar", 16'(bus.estado), 16'd4);
    sensor_apos2(1'b1);
    check("cx_espera", 16'(bus.estado), 16'd0);
    check("cx_fim", 16'(bus.fim), 16'd0);
    step();
    step();
    check("cx_still_idle", 16'(bus.estado), 16'd0);
    check("cx_no_spin", 16'(n_centr - base_centr), 16'd0);

    // Sensor and timeout in the same cycle
    iniciar();
    repeat (9) step();
    bus.cheio = 1'b1;
    step();
    bus.cheio = 1'b0;
    check("tie_agitar", 16'(bus.estado), 16'd2);
    bus.cancelar = 1'b1;
    step();
    bus.cancelar = 1'b0;
    check("tie_cancel", 16'(bus.estado), 16'd4);
    bus.vazio = 1'b1;
    step();
    bus.vazio = 1'b0;
    check("tie_espera", 16'(bus.estado), 16'd0);

    // Pause in AGITAR
    iniciar();
    sensor_apos2(1'b0);
`ifdef MAQUINA_PAUSA_EN
    step();
    bus.pausa = 1'b1;
    #1;
    check("pz_mot0", 16'(bus.modo_agitar), 16'd0);
    step();
    check("pz_mot1", 16'(bus.modo_agitar), 16'd0);
    step();
    check("pz_mot2", 16'(bus.modo_agitar), 16'd0);
    check("pz_hold", 16'(bus.estado), 16'd2);
    step();
    bus.pausa = 1'b0;
    #1;
    conta_fase(3'd2, n, na);
    check("pz_rest_dur", 16'(n), 16'd3);
    check("pz_rest_mot", 16'(na), 16'd3);
`else
    bus.pausa = 1'b1;
    #1;
    conta_fase(3'd2, n, na);
    bus.pausa = 1'b0;
    check("pz_ign_dur", 16'(n), 16'd4);
    check("pz_ign_mot", 16'(na), 16'd4);
`endif
    check("pz_girar", 16'(bus.estado), 16'd3);
    bus.cancelar = 1'b1;
    step();
    bus.cancelar = 1'b0;
    bus.vazio = 1'b1;
    step();
    bus.vazio = 1'b0;
    check("pz_espera", 16'(bus.estado), 16'd0);

    // Asynchronous reset during spin
    ate_centrifugar();
    check("ar_centrif", 16'(bus.estado), 16'd5);
    step();
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_estado", 16'(bus.estado), 16'd0);
    check("ar_out", 16'(saidas()), 16'h00);
    check("ar_passe", 16'(bus.passe), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("ar_idle", 16'(bus.estado), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
